pk_link_arb: RTL and testbench

- Frame-atomic arbiter that shares one serial uplink byte port between two packet sources.
- Source 0 is the science packet stream from the pack pipeline (pk_data/pk_vld/pk_frm domain). Source 1 is the housekeeping/command-reply stream.
- Grants one source per frame, forwards its bytes registered, and enforces an inter-frame gap.
- Aborts a stalled frame on watchdog timeout.

---
 rtl/pack_pkg.sv | 9 +
 rtl/pk_link_wdog.sv | 21 ++
 rtl/pk_link_arb.sv | 130 +++++++++++++
 tb/tb_pk_link_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pack_pkg.sv
// pack_pkg: shared state encodings and constants for the pack link controllers
package pack_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP = 2'd2;
    localparam logic [7:0] ABORT_BYTE = 8'hEE;
    localparam logic SRC_PK = 1'b0;
    localparam logic SRC_HK = 1'b1;
endpackage

// File: rtl/pk_link_wdog.sv
// pk_link_wdog: saturating stall counter that fires after TO_CYC cycles without a clear
module pk_link_wdog #(
    parameter int TO_CYC = 1024
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic fire
);
    localparam logic [15:0] LIM = 16'(TO_CYC - 1);
    logic [15:0] cnt_q, cnt_d;
    always_comb begin
        fire = en && !clr && cnt_q == LIM;
        cnt_d = (!en || clr || fire) ? 16'd0 : (cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1);
    end
    always_ff @(posedge clk_sys) begin
        if (!rst_n) cnt_q <= 16'd0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pk_link_arb.sv
// pk_link_arb: frame-atomic two-source uplink arbiter; define PK_LINK_ARB_STAT_EN for frame/abort counters
module pk_link_arb
    import pack_pkg::*;
#(
    parameter int GAP_CYC = 4,
    parameter int TO_CYC = 1024
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       cfg_en,
    input  logic       cfg_pri0,
    input  logic       req0,
    output logic       gnt0,
    input  logic [7:0] data0,
    input  logic       vld0,
    input  logic       eof0,
    input  logic       req1,
    output logic       gnt1,
    input  logic [7:0] data1,
    input  logic       vld1,
    input  logic       eof1,
    output logic [7:0] tx_data,
    output logic       tx_vld,
    output logic       tx_eof,
    output logic       busy,
    output logic       err_to
`ifdef PK_LINK_ARB_STAT_EN
    ,
    output logic [15:0] stat_frm0,
    output logic [15:0] stat_frm1,
    output logic [7:0]  stat_abort
`endif
);
    localparam logic [7:0] GAP_LD = 8'(GAP_CYC - 1);
    logic [1:0] state_q, state_d;
    logic       sel_q, sel_d, rr_last_q, rr_last_d;
    logic [7:0] gap_q, gap_d, tx_data_q, tx_data_d;
    logic       tx_vld_q, tx_vld_d, tx_eof_q, tx_eof_d, err_to_q;
    logic       xfer, g_vld, g_eof, g_end, win, fire;
    logic [7:0] g_data;
    pk_link_wdog #(.TO_CYC(TO_CYC)) u_wdog (
        .clk_sys(clk_sys),
        .rst_n  (rst_n),
        .en     (xfer),
        .clr    (g_vld),
        .fire   (fire)
    );
    always_comb begin
        xfer = state_q == ST_XFER;
        g_vld = xfer && (sel_q ? vld1 : vld0);
        g_eof = sel_q ? eof1 : eof0;
        g_data = sel_q ? data1 : data0;
        g_end = g_vld && g_eof;
        // contention: fixed priority favours source 0, otherwise alternate away from the last winner
        win = (req0 && req1) ? (cfg_pri0 ? SRC_PK : !rr_last_q) : (req1 ? SRC_HK : SRC_PK);
        state_d = state_q;
        sel_d = sel_q;
        rr_last_d = rr_last_q;
        gap_d = gap_q;
        if (state_q == ST_IDLE) begin
            if (cfg_en && (req0 || req1)) begin
                state_d = ST_XFER;
                sel_d = win;
                rr_last_d = win;
            end
        end else if (xfer) begin
            if (g_end || fire) begin
                state_d = ST_GAP;
                gap_d = GAP_LD;
            end
        end else begin
            state_d = gap_q == 8'd0 ? ST_IDLE : state_q;
            gap_d = gap_q == 8'd0 ? gap_q : gap_q - 8'd1;
        end
        tx_vld_d = g_vld || fire;
        tx_eof_d = g_end || fire;
        tx_data_d = g_vld ? g_data : (fire ? ABORT_BYTE : 8'h00);
    end
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q <= SRC_PK;
            rr_last_q <= SRC_HK;
            gap_q <= 8'd0;
            tx_data_q <= 8'h00;
            tx_vld_q <= 1'b0;
            tx_eof_q <= 1'b0;
            err_to_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q <= sel_d;
            rr_last_q <= rr_last_d;
            gap_q <= gap_d;
            tx_data_q <= tx_data_d;
            tx_vld_q <= tx_vld_d;
            tx_eof_q <= tx_eof_d;
            err_to_q <= fire;
        end
    end
    assign gnt0 = xfer && sel_q == SRC_PK;
    assign gnt1 = xfer && sel_q == SRC_HK;
    assign busy = state_q != ST_IDLE;
    assign tx_data = tx_data_q;
    assign tx_vld = tx_vld_q;
    assign tx_eof = tx_eof_q;
    assign err_to = err_to_q;
`ifdef PK_LINK_ARB_STAT_EN
    logic [15:0] frm0_q, frm0_d, frm1_q, frm1_d;
    logic [7:0]  abort_q, abort_d;
    always_comb begin
        frm0_d = frm0_q + 16'((g_end && sel_q == SRC_PK) ? 1 : 0);
        frm1_d = frm1_q + 16'((g_end && sel_q == SRC_HK) ? 1 : 0);
        abort_d = abort_q + 8'(fire ? 1 : 0);
    end
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            frm0_q <= 16'd0;
            frm1_q <= 16'd0;
            abort_q <= 8'd0;
        end else begin
            frm0_q <= frm0_d;
            frm1_q <= frm1_d;
            abort_q <= abort_d;
        end
    end
    assign stat_frm0 = frm0_q;
    assign stat_frm1 = frm1_q;
    assign stat_abort = abort_q;
`endif
endmodule

// File: tb/tb_pk_link_arb.sv
// tb_pk_link_arb: directed self-checking bench for pk_link_arb (GAP_CYC=4, TO_CYC=16)
module tb_pk_link_arb;
    logic       clk_sys, rst_n, cfg_en, cfg_pri0;
    logic       req0, vld0, eof0, req1, vld1, eof1;
    logic [7:0] data0, data1, tx_data;
    logic       gnt0, gnt1, tx_vld, tx_eof, busy, err_to;
    int         n_cmp = 0;
    int         n_err = 0;
`ifdef PK_LINK_ARB_STAT_EN
    logic [15:0] stat_frm0, stat_frm1;
    logic [7:0]  stat_abort;
`endif

    pk_link_arb #(.GAP_CYC(4), .TO_CYC(16)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_pri0(cfg_pri0),
        .req0(req0), .gnt0(gnt0), .data0(data0), .vld0(vld0), .eof0(eof0),
        .req1(req1), .gnt1(gnt1), .data1(data1), .vld1(vld1), .eof1(eof1),
        .tx_data(tx_data), .tx_vld(tx_vld), .tx_eof(tx_eof), .busy(busy), .err_to(err_to)
`ifdef PK_LINK_ARB_STAT_EN
        , .stat_frm0(stat_frm0), .stat_frm1(stat_frm1), .stat_abort(stat_abort)
`endif
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // grant edge, n bytes offered on both sources, eof on the last, then the 4-cycle gap
    task automatic run_frame(input logic src, input int n);
        tick;
        chk("grant_gnt0", {15'd0, gnt0}, {15'd0, !src});
        chk("grant_gnt1", {15'd0, gnt1}, {15'd0, src});
        chk("grant_busy", {15'd0, busy}, 16'd1);
        for (int i = 0; i < n; i++) begin
            data0 = 8'h10 + 8'(i);
            data1 = 8'h80 + 8'(i);
            vld0 = 1'b1;
            vld1 = 1'b1;
            eof0 = (i == n - 1);
            eof1 = (i == n - 1);
            tick;
            chk("fwd_vld", {15'd0, tx_vld}, 16'd1);
            chk("fwd_data", {8'd0, tx_data}, {8'd0, (src ? 8'h80 : 8'h10) + 8'(i)});
            chk("fwd_eof", {15'd0, tx_eof}, {15'd0, i == n - 1});
        end
        vld0 = 1'b0;
        vld1 = 1'b0;
        eof0 = 1'b0;
        eof1 = 1'b0;
        chk("eof_gnt_drop", {14'd0, gnt1, gnt0}, 16'd0);
        for (int g = 1; g <= 4; g++) begin
            tick;
            chk("gap_busy", {15'd0, busy}, {15'd0, g < 4});
            chk("gap_txvld", {15'd0, tx_vld}, 16'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_en = 1'b0;
        cfg_pri0 = 1'b0;
        {req0, vld0, eof0, req1, vld1, eof1} = '0;
        data0 = 8'h00;
        data1 = 8'h00;
        tick;
        tick;
        chk("rst_gnt", {14'd0, gnt1, gnt0}, 16'd0);
        chk("rst_tx", {6'd0, tx_data, tx_vld, tx_eof}, 16'd0);
        chk("rst_busy_err", {14'd0, busy, err_to}, 16'd0);
        rst_n = 1'b1;
        cfg_en = 1'b1;
        tick;
        chk("idle_no_req", {15'd0, busy}, 16'd0);

        // basic six-byte frame from source 0
        req0 = 1'b1;
        run_frame(1'b0, 6);
        req0 = 1'b0;

        // round-robin from reset: 0,1,0,1
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        run_frame(1'b0, 2);
        run_frame(1'b1, 3);
        run_frame(1'b0, 2);
        run_frame(1'b1, 2);

        // fixed priority: source 1 never wins
        cfg_pri0 = 1'b1;
        run_frame(1'b0, 2);
        run_frame(1'b0, 2);
        run_frame(1'b0, 2);

        // watchdog abort 16 cycles after last vld
        cfg_pri0 = 1'b0;
        req0 = 1'b0;
        tick;
        chk("to_grant", {14'd0, gnt1, gnt0}, 16'd2);
        vld1 = 1'b1;
        data1 = 8'hA1;
        tick;
        data1 = 8'hA2;
        tick;
        chk("to_byte2", {8'd0, tx_data}, 16'h00A2);
        vld1 = 1'b0;
        req1 = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick;
            chk("to_wait_err", {15'd0, err_to}, 16'd0);
            chk("to_wait_gnt", {15'd0, gnt1}, 16'd1);
        end
        tick;
        chk("to_err", {15'd0, err_to}, 16'd1);
        chk("to_marker", {6'd0, tx_data, tx_vld, tx_eof}, {6'd0, 8'hEE, 2'b11});
        chk("to_gnt_drop", {15'd0, gnt1}, 16'd0);
        tick;
        chk("to_err_pulse", {14'd0, err_to, tx_vld}, 16'd0);
        tick;
        tick;
        tick;
        chk("to_gap_done", {15'd0, busy}, 16'd0);

        // vld on the timeout cycle wins over the abort
        req1 = 1'b1;
        tick;
        chk("race_grant", {15'd0, gnt1}, 16'd1);
        vld1 = 1'b1;
        data1 = 8'h50;
        tick;
        vld1 = 1'b0;
        for (int k = 1; k <= 15; k++) tick;
        chk("race_pre_gnt", {15'd0, gnt1}, 16'd1);
        vld1 = 1'b1;
        eof1 = 1'b1;
        data1 = 8'h55;
        tick;
        chk("race_err", {15'd0, err_to}, 16'd0);
        chk("race_tx", {6'd0, tx_data, tx_vld, tx_eof}, {6'd0, 8'h55, 2'b11});
        chk("race_gnt_drop", {15'd0, gnt1}, 16'd0);
        {vld1, eof1, req1} = '0;
        for (int k = 0; k < 4; k++) tick;
        chk("race_idle", {15'd0, busy}, 16'd0);

        // cfg_en dropped mid-frame: frame completes, no new grant
        req0 = 1'b1;
        tick;
        chk("en_grant", {15'd0, gnt0}, 16'd1);
        vld0 = 1'b1;
        data0 = 8'h61;
        tick;
        cfg_en = 1'b0;
        data0 = 8'h62;
        tick;
        chk("en_hold_gnt", {15'd0, gnt0}, 16'd1);
        data0 = 8'h63;
        eof0 = 1'b1;
        tick;
        chk("en_eof", {6'd0, tx_data, tx_vld, tx_eof}, {6'd0, 8'h63, 2'b11});
        vld0 = 1'b0;
        eof0 = 1'b0;
        for (int k = 0; k < 8; k++) tick;
        chk("en_no_regrant", {13'd0, busy, gnt1, gnt0}, 16'd0);

        // reset mid-frame of source 1, then source 0 wins first
        cfg_en = 1'b1;
        req1 = 1'b1;
        tick;
        chk("rstm_grant", {14'd0, gnt1, gnt0}, 16'd2);
        vld1 = 1'b1;
        data1 = 8'h33;
        tick;
        chk("rstm_byte", {8'd0, tx_data}, 16'h0033);
        eof1 = 1'b1;
        rst_n = 1'b0;
        tick;
        chk("rstm_outs", {5'd0, gnt0, gnt1, busy, err_to, tx_vld, tx_eof, 5'd0}, 16'd0);
        chk("rstm_data", {8'd0, tx_data}, 16'd0);
        rst_n = 1'b1;
        vld1 = 1'b0;
        eof1 = 1'b0;
        tick;
        chk("rstm_first_win", {14'd0, gnt1, gnt0}, 16'd1);

        // three source-0 frames plus one abort
        req1 = 1'b0;
        vld0 = 1'b1;
        eof0 = 1'b1;
        data0 = 8'h42;
        tick;
        chk("st_frame_a", {8'd0, tx_data}, 16'h0042);
        vld0 = 1'b0;
        eof0 = 1'b0;
        for (int k = 0; k < 4; k++) tick;
        run_frame(1'b0, 1);
        run_frame(1'b0, 1);
        tick;
        chk("st_abort_grant", {15'd0, gnt0}, 16'd1);
        req0 = 1'b0;
        for (int k = 1; k <= 15; k++) tick;
        chk("st_pre_abort", {15'd0, err_to}, 16'd0);
        tick;
        chk("st_abort", {15'd0, err_to}, 16'd1);
`ifdef PK_LINK_ARB_STAT_EN
        chk("stat_frm0", stat_frm0, 16'd3);
        chk("stat_frm1", stat_frm1, 16'd0);
        chk("stat_abort", {8'd0, stat_abort}, 16'd1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
